led_fade_pwm: RTL and testbench



---
 rtl/led_pkg.sv | 14 +
 rtl/led_fade_channel.sv | 55 +++++
 rtl/led_fade_pwm.sv | 60 ++++++
 tb/tb_led_fade_pwm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED polarity constants, channel-count default and the saturating decay helper.
// Pure definitions: no latency, no backpressure.
package led_pkg;

  localparam int   DEFAULT_N_LED = 4;
  localparam logic LED_ON        = 1'b0;
  localparam logic LED_OFF       = 1'b1;

  // Decrement that clamps at zero instead of wrapping to full brightness.
  function automatic logic [31:0] sat_sub(input logic [31:0] level, input logic [31:0] step);
    return (level > step) ? (level - step) : 32'd0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with decay, period-aligned shadow and registered PWM pin.
// Latency: lit -> level 1 clk, level -> pin within one PWM period + 2 clks; no backpressure.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int DECAY_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lit,
  input  logic             tick,
  input  logic             fade_en,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             period_end,
  output logic             pwm_n,
  output logic             active
);

  localparam logic [PWM_W-1:0] MAX_LEVEL = '1;

  logic [PWM_W-1:0] level;
  logic [PWM_W-1:0] level_next;
  logic [PWM_W-1:0] shadow;

  // Lit always beats a decay tick; bypass tracks the input directly.
  always_comb begin
    level_next = level;
    if (!fade_en) begin
      level_next = lit ? MAX_LEVEL : '0;
    end else if (lit) begin
      level_next = MAX_LEVEL;
    end else if (tick) begin
      level_next = PWM_W'(sat_sub(32'(level), 32'(DECAY_STEP)));
    end
  end

  assign active = (level != '0);

  // Shadow captures the pre-update level so a period never changes duty mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= '0;
      shadow <= '0;
      pwm_n  <= LED_OFF;
    end else begin
      level <= level_next;
      if (period_end) begin
        shadow <= level;
      end
      pwm_n <= (pwm_cnt < shadow) ? LED_ON : LED_OFF;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Comet-tail PWM stage between the rotating LED pattern generator and the pio_led pins.
// Latency: pattern edge -> level 1 clk, -> pin at most 2^PWM_W + 2 clks; no backpressure.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int N_LED      = DEFAULT_N_LED,
  parameter int PWM_W      = 8,
  parameter int FADE_DIV   = 1024,
  parameter int DECAY_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             any_active
);

  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [PWM_W-1:0] pwm_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             period_end;
  logic [N_LED-1:0] active_vec;

  // With FADE_DIV == 1 the divider sits at 0 and tick stays high.
  assign tick       = (div_cnt == DIV_W'(FADE_DIV - 1));
  assign period_end = (pwm_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt    <= '0;
      div_cnt    <= '0;
      any_active <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_W'(1);
      div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
      any_active <= |active_vec;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_channel #(
      .PWM_W      (PWM_W),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .lit        (led_in[i] == LED_ON),
      .tick       (tick),
      .fade_en    (fade_en),
      .pwm_cnt    (pwm_cnt),
      .period_end (period_end),
      .pwm_n      (led_out[i]),
      .active     (active_vec[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

  localparam int N_LED      = 4;
  localparam int PWM_W      = 4;
  localparam int MAX_LEVEL  = 15;
  localparam int FADE_DIV   = 4;
  localparam int DECAY_STEP = 3;

  logic             clk;
  logic             rst_n;
  logic [N_LED-1:0] led_in;
  logic             fade_en;
  logic [N_LED-1:0] led_out;
  logic             any_active;

  led_fade_pwm #(
    .N_LED      (N_LED),
    .PWM_W      (PWM_W),
    .FADE_DIV   (FADE_DIV),
    .DECAY_STEP (DECAY_STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .fade_en    (fade_en),
    .led_out    (led_out),
    .any_active (any_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_LED-1:0] led;
    logic             act;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_pwm;
  int   m_div;
  int   m_level  [N_LED];
  int   m_shadow [N_LED];
  int   lit_cnt;

  task automatic check(input string tag, input logic [N_LED-1:0] got, input logic [N_LED-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pwm = 0;
    m_div = 0;
    for (int i = 0; i < N_LED; i++) begin
      m_level[i]  = 0;
      m_shadow[i] = 0;
    end
    q.delete();
  endtask

  // Predict this edge's outputs from the spec model, then advance DUT one clock and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    logic tk;
    logic pe;
    logic lt;
    e.act = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      e.led[i] = (m_pwm < m_shadow[i]) ? 1'b0 : 1'b1;
      if (m_level[i] != 0) e.act = 1'b1;
    end
    q.push_back(e);
    tk = (m_div == FADE_DIV - 1);
    pe = (m_pwm == MAX_LEVEL);
    for (int i = 0; i < N_LED; i++) begin
      lt = (led_in[i] == 1'b0);
      if (pe) m_shadow[i] = m_level[i];
      if (!fade_en)  m_level[i] = lt ? MAX_LEVEL : 0;
      else if (lt)   m_level[i] = MAX_LEVEL;
      else if (tk)   m_level[i] = (m_level[i] > DECAY_STEP) ? m_level[i] - DECAY_STEP : 0;
    end
    m_pwm = (m_pwm + 1) % (MAX_LEVEL + 1);
    m_div = (m_div + 1) % FADE_DIV;
    @(posedge clk);
    #1;
    got = q.pop_front();
    if (led_out[3] == 1'b0) lit_cnt++;
    check("led_out", led_out, got.led);
    check("any_active", {3'b000, any_active}, {3'b000, got.act});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int   budget;
    logic quiet;

    rst_n   = 1'b0;
    led_in  = 4'b1111;
    fade_en = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_led_out", led_out, 4'b1111);
    check("reset_any_active", {3'b000, any_active}, 4'b0000);
    rst_n = 1'b1;
    run(4);

    // Full on: steady state lights 15 of every 16 clocks
    led_in = 4'b0111;
    run(40);
    for (int w = 0; w < 3; w++) begin
      lit_cnt = 0;
      run(16);
      check("full_on_duty", 4'(lit_cnt), 4'(15));
    end

    // Asynchronous reset mid-period with levels nonzero
    run(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led_out", led_out, 4'b1111);
    check("async_reset_any_active", {3'b000, any_active}, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(40);

    // Fade out after release, bounded wait for any_active to drop
    led_in = 4'b1111;
    budget = 0;
    while (any_active !== 1'b0 && budget < 200) begin
      step();
      budget++;
    end
    check("fade_completes", {3'b000, any_active}, 4'b0000);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (led_out !== 4'b1111 || any_active !== 1'b0) quiet = 1'b0;
    end
    check("saturate_stays_dark", {3'b000, quiet}, 4'b0001);

    // Relight at level 6 in a tick cycle
    led_in = 4'b0111;
    run(40);
    led_in = 4'b1111;
    budget = 0;
    while (!(m_level[3] == 6 && m_div == FADE_DIV - 1) && budget < 100) begin
      step();
      budget++;
    end
    check("relight_reached_level6", {3'b000, (budget < 100)}, 4'b0001);
    led_in = 4'b0111;
    step();
    led_in = 4'b1111;
    run(60);

    // Rotating pattern, bypass: no tail once released
    fade_en = 1'b0;
    led_in = 4'b0111; run(16);
    led_in = 4'b1011; run(16);
    led_in = 4'b1101; run(16);
    led_in = 4'b1110; run(16);
    led_in = 4'b1111; run(2);
    check("bypass_no_tail", {3'b000, any_active}, 4'b0000);
    run(20);

    // Rotating pattern with fade, then kill the tail by leaving fade mode
    fade_en = 1'b1;
    led_in = 4'b0111; run(16);
    led_in = 4'b1011; run(16);
    led_in = 4'b1101; run(16);
    led_in = 4'b1110; run(16);
    led_in = 4'b1111; run(3);
    check("fade_tail_present", {3'b000, any_active}, 4'b0001);
    fade_en = 1'b0;
    run(2);
    check("bypass_kills_tail", {3'b000, any_active}, 4'b0000);
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
